lfsr_gen: RTL
=============

# lfsr_gen

Parametrised Fibonacci LFSR with four operating modes: hold, run, serial seed shift-in and parallel seed load. It generalises our fixed 6-bit shift-in/feedback register in four ways:
- configurable width and tap mask;
- synchronous reset to a known state;
- all-zero lock-up detection with optional auto-recovery;
- a period monitor that flags each time the sequence returns to its start state and reports the measured period.

It sits beside the pattern generators as the pseudo-random source for stimulus and scrambler logic.

## Interface
Parameters:
- WIDTH, 6, register length; must be ≥ 3.
- TAPS, 6'b110000, feedback mask. Bit i set means out[i] is XORed into the feedback. TAPS[WIDTH-1] must be 1.
- RESET_VAL, 1, state loaded on reset and on recovery. Must be non-zero.
- AUTO_RECOVER, 1, 1 = an all-zero state in run mode is replaced by RESET_VAL.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- mode  in  2  operating mode: 00 hold, 01 run, 10 serial shift-in, 11 parallel load.
- seed_bit  in  1  serial seed bit, used in mode 10.
- seed  in  WIDTH  parallel seed, used in mode 11.
- out  out  WIDTH  LFSR state.
- serial_out  out  1  equal to out[WIDTH-1].
- lockup  out  1  high exactly while out == 0.
- wrap  out  1  one-cycle pulse: state has returned to the start state.
- period  out  WIDTH  step count at the most recent wrap; 0 until the first wrap.
- steps  out  WIDTH  run steps since the start state was last set; saturates at all-ones.

## Operation
- fb = XOR-reduce(out & TAPS).
- Mode 00, hold: all registers keep their values.
- Mode 01, run: out ← {out[WIDTH-2:0], fb}. steps ← steps+1, saturating.
- Mode 10, serial: out ← {out[WIDTH-2:0], seed_bit}. The start state is set to the new out. steps ← 0.
- Mode 11, load: out ← seed. The start state is set to seed. steps ← 0.
- Wrap: in run mode, if the next out equals the start state:
  - wrap ← 1 and period ← steps+1;
  - steps ← 0.
  - In all other cycles wrap ← 0.
- Lock-up, when out == 0 and mode == 01:
  - AUTO_RECOVER = 1: out ← RESET_VAL, start state ← RESET_VAL, steps ← 0. No wrap pulse.
  - AUTO_RECOVER = 0: the state stays 0 (natural behaviour of the feedback). steps keeps counting. Wrap fires every step, because the start state is 0.
- Hold, serial and load modes never trigger recovery, so out == 0 may be held or loaded.
- Reset has priority over mode. It applies in any cycle, including mid-run or mid-serial-seed:
  - out ← RESET_VAL, start state ← RESET_VAL;
  - steps ← 0, period ← 0, wrap ← 0.
- Outputs are registered, except lockup and serial_out, which are decoded directly from out.

## Timing
- Every state change takes effect on the clk edge where mode is sampled. There is no pipeline latency.
- wrap rises in the same cycle that out becomes equal to the start state. It lasts exactly one cycle unless the next step also wraps.
- period updates in the same cycle as the wrap pulse.
- Default parameters are maximal length: from RESET_VAL, 63 consecutive run cycles reach wrap with period = 63.
- Changing mode mid-sequence requires no settling cycles.

## Structure
- Package lfsr_pkg holds:
  - mode encodings: MODE_HOLD, MODE_RUN, MODE_SHIFT, MODE_LOAD;
  - a 2-bit mode typedef.
- Sub-module lfsr_period_mon holds the start-state register, the steps counter, the period register and the wrap compare. It takes the next-state value and mode-derived strobes, which keeps the top level to the shift/feedback datapath.

## Test plan
- Reset, then run with defaults: out = 000001 → 000010 → 000100 → 001000 → 010000 → 100001 → 000011.
- Run 63 cycles from reset: wrap is high only on cycle 63, period = 63, steps = 0 after the wrap.
- Mode 11 with seed = 101010, then run: out = 101010 → 010101. steps = 1, start state = 101010.
- Mode 10 six times with seed_bit pattern 1,0,1,1,0,0: out = 101100, steps = 0.
- Load seed = 0:
  - lockup = 1;
  - next run cycle with AUTO_RECOVER = 1: out = 000001, lockup = 0, wrap = 0;
  - with AUTO_RECOVER = 0: out stays 0 and wrap pulses each run cycle.
- Assert rst mid-run at steps = 20: next cycle out = 000001, steps = 0, period = 0, wrap = 0. rst overrides mode 11 when both are applied together.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared mode encodings and helpers for the lfsr_gen block.
package lfsr_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_HOLD  = 2'b00;
   localparam mode_t MODE_RUN   = 2'b01;
   localparam mode_t MODE_SHIFT = 2'b10;
   localparam mode_t MODE_LOAD  = 2'b11;

   // Serial shift-in and parallel load both define a new start state.
   function automatic logic mode_sets_start(input mode_t m);
      return (m == MODE_SHIFT) || (m == MODE_LOAD);
   endfunction

endpackage

// File: rtl/lfsr_period_mon.sv
// Start-state tracker: step counter, wrap compare and measured period.
module lfsr_period_mon
#(
   parameter int unsigned     WIDTH     = 6,
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(1)
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] nxt,
   input  logic             step,
   input  logic             restart,
   output logic             wrap,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] steps
);

   logic [WIDTH-1:0] start;
   logic [WIDTH-1:0] steps_inc;

   // Saturating increment so a stuck or very long sequence never rolls the count.
   always_comb begin
      steps_inc = steps;
      if (steps != '1) begin
         steps_inc = steps + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         start  <= RESET_VAL;
         steps  <= '0;
         period <= '0;
         wrap   <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (restart) begin
            start <= nxt;
            steps <= '0;
         end else if (step) begin
            if (nxt == start) begin
               wrap   <= 1'b1;
               period <= steps_inc;
               steps  <= '0;
            end else begin
               steps <= steps_inc;
            end
         end
      end
   end

endmodule

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR with hold/run/serial-seed/parallel-load modes and period monitor.
module lfsr_gen
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH        = 6,
   parameter logic [WIDTH-1:0] TAPS         = WIDTH'(6'b110000),
   parameter logic [WIDTH-1:0] RESET_VAL    = WIDTH'(1),
   parameter bit               AUTO_RECOVER = 1'b1
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode,
   input  logic             seed_bit,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] out,
   output logic             serial_out,
   output logic             lockup,
   output logic             wrap,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] steps
);

   logic             fb;
   logic [WIDTH-1:0] nxt;
   logic             step;
   logic             restart;

   // Next-state datapath; recovery only applies to the running register.
   always_comb begin
      fb      = ^(out & TAPS);
      nxt     = out;
      step    = 1'b0;
      restart = 1'b0;
      case (mode_t'(mode))
         MODE_RUN: begin
            if ((out == '0) && AUTO_RECOVER) begin
               nxt     = RESET_VAL;
               restart = 1'b1;
            end else begin
               nxt  = {out[WIDTH-2:0], fb};
               step = 1'b1;
            end
         end
         MODE_SHIFT: nxt = {out[WIDTH-2:0], seed_bit};
         MODE_LOAD:  nxt = seed;
         default:    nxt = out;
      endcase
      if (mode_sets_start(mode_t'(mode))) begin
         restart = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out <= RESET_VAL;
      end else begin
         out <= nxt;
      end
   end

   assign serial_out = out[WIDTH-1];
   assign lockup     = (out == '0);

   lfsr_period_mon #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) u_period_mon (
      .clk     (clk),
      .rst     (rst),
      .nxt     (nxt),
      .step    (step),
      .restart (restart),
      .wrap    (wrap),
      .period  (period),
      .steps   (steps)
   );

endmodule
